fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Instruction buffer between the fetch stage (IF) and decode (ID). Captures each
//   fetched {instruction, PC, PC+4} triple and presents the oldest entry to ID.
//   Decouples ID stalls from fetch. Empties in one cycle on a branch redirect.
//   Full-queue backpressure drives the IF STALL input.
// PARAMETERS
//   DEPTH  4  number of entries; power of two, >= 2
//   AW     2  log2(DEPTH); pointer width
// PORTS
//   CLK           in   1    clock, rising edge
//   RESET         in   1    asynchronous, active-low reset
//   Enq_Valid     in   1    IF presents a valid fetched instruction this cycle
//   Enq_Instr     in   32   fetched instruction word (IF Instr1_OUT)
//   Enq_PC        in   32   address of fetched instruction (IF Instr_PC_OUT)
//   Enq_PC_Plus4  in   32   address of following instruction (IF Instr_PC_Plus4)
//   Enq_Stall     out  1    queue full; connected to IF STALL
//   Flush         in   1    redirect; discard all entries (asserted with Request_Alt_PC)
//   Deq_Ready     in   1    ID consumes the head entry this cycle
//   Deq_Valid     out  1    head entry is valid
//   Deq_Instr     out  32   head instruction; 32'h0 (NOP) when empty
//   Deq_PC        out  32   head PC; 0 when empty
//   Deq_PC_Plus4  out  32   head PC+4; 0 when empty
//   Count         out  AW+1 number of valid entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (RESET=0, async): rd_ptr=wr_ptr=0 and Count=0. Deq_Valid=0.
//     Deq_Instr/Deq_PC/Deq_PC_Plus4=0. Enq_Stall=0.
//     Storage array is not reset; outputs are gated by Deq_Valid.
//   - Reset mid-operation discards all contents immediately, not at the next edge.
//   - Storage: DEPTH entries x 96 bits. Pointers are AW bits and wrap modulo DEPTH.
//     Count is held separately, so full and empty are unambiguous.
//   - Flag definitions:
//       full  = (Count == DEPTH)
//       empty = (Count == 0)
//       Deq_Valid = !empty
//       Enq_Stall = full (combinational from registered Count only; no path from Deq_Ready)
//   - push = Enq_Valid && !full && !Flush. A push writes entry[wr_ptr] and advances wr_ptr.
//   - pop = Deq_Ready && Deq_Valid && !Flush. A pop advances rd_ptr.
//   - Count next-state:
//       +1 on push only; -1 on pop only; unchanged when both or neither.
//   - Full + pop + Enq_Valid in the same cycle: the push is rejected (Enq_Stall already 1).
//     Count becomes DEPTH-1. IF holds that instruction and re-presents it.
//   - Empty: no bypass. An entry pushed at edge N is visible on Deq_* after edge N.
//     Minimum enqueue-to-dequeue latency is 1 cycle.
//   - Deq_* outputs: combinational read of entry[rd_ptr], forced to 0 when empty.
//   - Flush (priority over push and pop):
//       at the next edge, rd_ptr=wr_ptr=0 and Count=0; a same-cycle Enq_Valid is dropped.
//       The first instruction after the redirect is pushed from the cycle after Flush.
//       Delay-slot handling is upstream: Flush is asserted only after the slot is enqueued.
//   - Enq_Valid while full (no flush): ignored; no state change.
//   - Deq_Ready while empty: ignored.
//   - FIFO order is preserved across pointer wrap.
// TESTING
//   1 Reset mid-stream:
//       3 entries queued, drop RESET -> same cycle Count=0, Deq_Valid=0,
//       Deq_Instr=0, Enq_Stall=0.
//   2 Fill:
//       Deq_Ready=0; push 0x20010001..0x20010005 at PC 0xBFC00000 step 4.
//       -> Count=4, Enq_Stall=1, 5th rejected.
//       Then Deq_Ready=1 -> heads 0x20010001..04 in order,
//       Deq_PC_Plus4 = Deq_PC+4 for each.
//   3 Streaming at Count=2:
//       push and pop every cycle for 6 cycles -> Count stays 2, no loss or duplication.
//   4 Full + pop + push same cycle:
//       -> push rejected, Count=3, Enq_Stall=0 next cycle.
//       Re-presented instruction is accepted next cycle.
//   5 Flush with Count=3, Enq_Valid=1, Deq_Ready=1:
//       -> next cycle Count=0, Deq_Valid=0.
//       Push of 0xBFC00100 the following cycle appears on Deq_PC one edge later.
//   6 Wrap-around:
//       20 push/pop pairs with random Deq_Ready gaps -> output PC sequence
//       0xBFC00000+4k exact, Count never exceeds 4.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between IF and ID.
// Holds {instr, pc, pc+4} triples in FIFO order; the oldest entry is shown on
// Deq_*. A separate occupancy counter keeps full/empty unambiguous. Flush
// empties the queue in one cycle, and a full queue stalls IF.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Enq_Valid,
  input  logic [31:0]   Enq_Instr,
  input  logic [31:0]   Enq_PC,
  input  logic [31:0]   Enq_PC_Plus4,
  output logic          Enq_Stall,
  input  logic          Flush,
  input  logic          Deq_Ready,
  output logic          Deq_Valid,
  output logic [31:0]   Deq_Instr,
  output logic [31:0]   Deq_PC,
  output logic [31:0]   Deq_PC_Plus4,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [95:0]   mem_q [DEPTH];
  logic [95:0]   head;
  logic          full, empty, push, pop;

  // Flags and handshakes derived from registered occupancy only.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    push  = Enq_Valid && !full && !Flush;
    pop   = Deq_Ready && !empty && !Flush;
  end

  // Pointer and occupancy next-state; Flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; not reset, since outputs are gated by Deq_Valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {Enq_Instr, Enq_PC, Enq_PC_Plus4};
  end

  // Head read, forced to zero (NOP) while empty; no enqueue bypass.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    Deq_Valid    = !empty;
    Enq_Stall    = full;
    Count        = count_q;
    Deq_Instr    = '0;
    Deq_PC       = '0;
    Deq_PC_Plus4 = '0;
    if (!empty) begin
      Deq_Instr    = head[95:64];
      Deq_PC       = head[63:32];
      Deq_PC_Plus4 = head[31:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Enq_Valid;
  logic [31:0] Enq_Instr, Enq_PC, Enq_PC_Plus4;
  logic        Enq_Stall;
  logic        Flush;
  logic        Deq_Ready;
  logic        Deq_Valid;
  logic [31:0] Deq_Instr, Deq_PC, Deq_PC_Plus4;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .Enq_Valid(Enq_Valid), .Enq_Instr(Enq_Instr), .Enq_PC(Enq_PC),
    .Enq_PC_Plus4(Enq_PC_Plus4), .Enq_Stall(Enq_Stall), .Flush(Flush),
    .Deq_Ready(Deq_Ready), .Deq_Valid(Deq_Valid), .Deq_Instr(Deq_Instr),
    .Deq_PC(Deq_PC), .Deq_PC_Plus4(Deq_PC_Plus4), .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    Enq_Valid    = v;
    Enq_Instr    = instr;
    Enq_PC       = pc;
    Enq_PC_Plus4 = pc + 32'd4;
  endtask

  initial begin
    int push_k, pop_k, cyc, occ;
    logic dr, mfull;
    RESET = 1'b0; Flush = 1'b0; Deq_Ready = 1'b0;
    present(1'b0, '0, '0);
    tick(); tick();
    check("rst_count", 32'(Count), 32'd0);
    check("rst_valid", 32'(Deq_Valid), 32'd0);
    check("rst_instr", Deq_Instr, 32'd0);
    check("rst_stall", 32'(Enq_Stall), 32'd0);
    RESET = 1'b1;

    // 1: reset mid-stream clears immediately
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 32'h1000_0000 + 32'(i), 32'h0000_1000 + 32'(4*i));
      tick();
    end
    present(1'b0, '0, '0);
    check("t1_count3", 32'(Count), 32'd3);
    #2 RESET = 1'b0;
    #1;
    check("t1_count", 32'(Count), 32'd0);
    check("t1_valid", 32'(Deq_Valid), 32'd0);
    check("t1_instr", Deq_Instr, 32'd0);
    check("t1_stall", 32'(Enq_Stall), 32'd0);
    tick();
    RESET = 1'b1;

    // 2: fill, 5th rejected, drain in order
    for (int i = 0; i < 5; i++) begin
      present(1'b1, 32'h2001_0001 + 32'(i), 32'hBFC0_0000 + 32'(4*i));
      if (i == 4) check("t2_stall_full", 32'(Enq_Stall), 32'd1);
      tick();
    end
    present(1'b0, '0, '0);
    check("t2_count_full", 32'(Count), 32'd4);
    Deq_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_valid", 32'(Deq_Valid), 32'd1);
      check("t2_instr", Deq_Instr, 32'h2001_0001 + 32'(i));
      check("t2_pc", Deq_PC, 32'hBFC0_0000 + 32'(4*i));
      check("t2_pc4", Deq_PC_Plus4, 32'hBFC0_0004 + 32'(4*i));
      tick();
    end
    check("t2_empty_valid", 32'(Deq_Valid), 32'd0);
    check("t2_empty_instr", Deq_Instr, 32'd0);
    check("t2_empty_count", 32'(Count), 32'd0);
    Deq_Ready = 1'b0;

    // 3: streaming at Count=2
    for (int k = 0; k < 2; k++) begin
      present(1'b1, 32'h3000_0000 + 32'(k), 32'h0000_2000 + 32'(4*k));
      tick();
    end
    Deq_Ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      present(1'b1, 32'h3000_0000 + 32'(k), 32'h0000_2000 + 32'(4*k));
      check("t3_count", 32'(Count), 32'd2);
      check("t3_instr", Deq_Instr, 32'h3000_0000 + 32'(k-2));
      tick();
    end
    present(1'b0, '0, '0);
    for (int k = 6; k < 8; k++) begin
      check("t3_tail", Deq_Instr, 32'h3000_0000 + 32'(k));
      tick();
    end
    check("t3_empty", 32'(Count), 32'd0);
    Deq_Ready = 1'b0;

    // 4: full + pop + push in the same cycle
    for (int k = 0; k < 4; k++) begin
      present(1'b1, 32'h4000_0000 + 32'(k), 32'h0000_3000 + 32'(4*k));
      tick();
    end
    present(1'b1, 32'h4000_0004, 32'h0000_3010);
    Deq_Ready = 1'b1;
    check("t4_stall", 32'(Enq_Stall), 32'd1);
    tick();
    Deq_Ready = 1'b0;
    check("t4_count3", 32'(Count), 32'd3);
    check("t4_stall_clr", 32'(Enq_Stall), 32'd0);
    check("t4_head", Deq_Instr, 32'h4000_0001);
    tick();
    present(1'b0, '0, '0);
    check("t4_count4", 32'(Count), 32'd4);
    Deq_Ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check("t4_order", Deq_Instr, 32'h4000_0000 + 32'(k));
      tick();
    end
    Deq_Ready = 1'b0;

    // 5: flush with Count=3, Enq_Valid and Deq_Ready high
    for (int k = 0; k < 3; k++) begin
      present(1'b1, 32'h5000_0000 + 32'(k), 32'h0000_4000 + 32'(4*k));
      tick();
    end
    present(1'b1, 32'h5000_0003, 32'h0000_400C);
    Deq_Ready = 1'b1; Flush = 1'b1;
    tick();
    Flush = 1'b0; Deq_Ready = 1'b0;
    check("t5_count", 32'(Count), 32'd0);
    check("t5_valid", 32'(Deq_Valid), 32'd0);
    present(1'b1, 32'h6000_00AA, 32'hBFC0_0100);
    tick();
    present(1'b0, '0, '0);
    check("t5_pc", Deq_PC, 32'hBFC0_0100);
    check("t5_instr", Deq_Instr, 32'h6000_00AA);
    check("t5_count1", 32'(Count), 32'd1);
    Deq_Ready = 1'b1;
    tick();
    Deq_Ready = 1'b0;

    // 6: wrap-around with random consumer gaps, scoreboard by index
    push_k = 0; pop_k = 0; cyc = 0;
    while (pop_k < 20 && cyc < 400) begin
      occ   = push_k - pop_k;
      mfull = (occ == 4);
      dr    = 1'($urandom_range(0, 1));
      present(push_k < 20, 32'h7000_0000 + 32'(push_k), 32'hBFC0_0000 + 32'(4*push_k));
      Deq_Ready = dr;
      check("t6_count", 32'(Count), 32'(occ));
      check("t6_stall", 32'(Enq_Stall), 32'(mfull));
      check("t6_max", 32'(Count <= 3'd4), 32'd1);
      if (occ > 0) check("t6_pc", Deq_PC, 32'hBFC0_0000 + 32'(4*pop_k));
      tick();
      if (push_k < 20 && !mfull) push_k++;
      if (dr && occ > 0) pop_k++;
      cyc++;
    end
    present(1'b0, '0, '0);
    Deq_Ready = 1'b0;
    check("t6_done", 32'(pop_k), 32'd20);
    check("t6_final_count", 32'(Count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
